// File: rtl/vmc_wb_port_arb.sv
// Wishbone B3 multi-port front end for the versatile memory controller.
// Arbitrates N slave ports onto one burst command / write / read channel.
module vmc_wb_port_arb #(
  parameter int unsigned nr_of_wb_ports = 3,
  parameter int unsigned adr_width      = 30,
  parameter int unsigned dat_width      = 32,
  parameter int unsigned arb_mode       = 0
) (
  input  logic                                    wb_clk,
  input  logic                                    wb_rst,
  input  logic [adr_width*nr_of_wb_ports-1:0]     wb_adr_i_v,
  input  logic [dat_width*nr_of_wb_ports-1:0]     wb_dat_i_v,
  input  logic [(dat_width/8)*nr_of_wb_ports-1:0] wb_sel_i_v,
  input  logic [3*nr_of_wb_ports-1:0]             wb_cti_i_v,
  input  logic [2*nr_of_wb_ports-1:0]             wb_bte_i_v,
  input  logic [nr_of_wb_ports-1:0]               wb_we_i,
  input  logic [nr_of_wb_ports-1:0]               wb_stb_i,
  input  logic [nr_of_wb_ports-1:0]               wb_cyc_i,
  output logic [dat_width*nr_of_wb_ports-1:0]     wb_dat_o_v,
  output logic [nr_of_wb_ports-1:0]               wb_ack_o,
  output logic                                    mem_cmd_valid_o,
  input  logic                                    mem_cmd_ready_i,
  output logic [adr_width-1:0]                    mem_adr_o,
  output logic                                    mem_we_o,
  output logic [4:0]                              mem_len_o,
  output logic                                    mem_wrap_o,
  output logic [2:0]                              mem_port_o,
  output logic                                    mem_wdat_valid_o,
  output logic [dat_width-1:0]                    mem_wdat_o,
  output logic [dat_width/8-1:0]                  mem_wsel_o,
  input  logic                                    mem_wdat_ready_i,
  input  logic                                    mem_rdat_valid_i,
  input  logic [dat_width-1:0]                    mem_rdat_i
);

  localparam int unsigned n         = nr_of_wb_ports;
  localparam int unsigned sw        = dat_width / 8;
  localparam int unsigned max_ports = 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_WR, ST_PAD, ST_RD, ST_DRAIN
  } state_t;

  state_t               state;
  logic [2:0]           grant;
  logic [2:0]           rr_ptr;
  logic [2:0]           win;
  logic [4:0]           win_len;
  logic                 win_wrap;
  logic [4:0]           beat_cnt;
  logic [adr_width-1:0] adr_q;
  logic                 we_q;
  logic [4:0]           len_q;
  logic                 wrap_q;
  logic [dat_width-1:0] rd_dat_q;
  logic [n-1:0]         rd_ack_q;
  logic [n-1:0]         wr_ack_c;
  logic                 g_req;
  logic [7:0]           cyc8;
  logic [7:0]           stb8;
  logic [7:0]           we8;
  logic [7:0]           req;

  logic [adr_width-1:0] adr_a [max_ports];
  logic [dat_width-1:0] dat_a [max_ports];
  logic [sw-1:0]        sel_a [max_ports];
  logic [2:0]           cti_a [max_ports];
  logic [1:0]           bte_a [max_ports];

  // Port 0 sits in the MSBs of every packed per-port bus; unused slots read as 0.
  for (genvar p = 0; p < max_ports; p++) begin : g_unpack
    if (p < n) begin : g_used
      assign adr_a[p] = wb_adr_i_v[(n-1-p)*adr_width +: adr_width];
      assign dat_a[p] = wb_dat_i_v[(n-1-p)*dat_width +: dat_width];
      assign sel_a[p] = wb_sel_i_v[(n-1-p)*sw +: sw];
      assign cti_a[p] = wb_cti_i_v[(n-1-p)*3 +: 3];
      assign bte_a[p] = wb_bte_i_v[(n-1-p)*2 +: 2];
    end else begin : g_unused
      assign adr_a[p] = '0;
      assign dat_a[p] = '0;
      assign sel_a[p] = '0;
      assign cti_a[p] = '0;
      assign bte_a[p] = '0;
    end
  end

  assign cyc8 = 8'(wb_cyc_i);
  assign stb8 = 8'(wb_stb_i);
  assign we8  = 8'(wb_we_i);
  assign req  = cyc8 & stb8;

  // Winner selection: circular after the last grant, or lowest index first.
  always_comb begin
    logic       found;
    logic [3:0] idx;
    win   = rr_ptr;
    found = 1'b0;
    idx   = '0;
    if (arb_mode == 1) begin
      for (int i = int'(n) - 1; i >= 0; i--) begin
        if (req[3'(i)]) win = 3'(i);
      end
    end else begin
      for (int i = 1; i <= int'(n); i++) begin
        idx = 4'(rr_ptr) + 4'(i);
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (!found && req[idx[2:0]]) begin
          win   = idx[2:0];
          found = 1'b1;
        end
      end
    end
  end

  // Only wrap bursts become multi-beat commands; everything else is one beat.
  always_comb begin
    win_len  = 5'd1;
    win_wrap = 1'b0;
    if (cti_a[win] == 3'b010) begin
      case (bte_a[win])
        2'b01:   begin win_len = 5'd4;  win_wrap = 1'b1; end
        2'b10:   begin win_len = 5'd8;  win_wrap = 1'b1; end
        2'b11:   begin win_len = 5'd16; win_wrap = 1'b1; end
        default: begin win_len = 5'd1;  win_wrap = 1'b0; end
      endcase
    end
  end

  // Write path passes straight through from the granted port.
  always_comb begin
    g_req            = cyc8[grant] & stb8[grant];
    wr_ack_c         = '0;
    mem_wdat_valid_o = 1'b0;
    mem_wdat_o       = '0;
    mem_wsel_o       = '0;
    case (state)
      ST_WR: begin
        mem_wdat_valid_o = g_req;
        mem_wdat_o       = dat_a[grant];
        mem_wsel_o       = sel_a[grant];
        for (int p = 0; p < int'(n); p++) begin
          wr_ack_c[p] = (grant == 3'(p)) & g_req & mem_wdat_ready_i;
        end
      end
      ST_PAD:  mem_wdat_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= 3'(n - 1);
      beat_cnt <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      len_q    <= '0;
      wrap_q   <= 1'b0;
      rd_dat_q <= '0;
      rd_ack_q <= '0;
    end else begin
      rd_ack_q <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant  <= win;
            rr_ptr <= win;
            adr_q  <= adr_a[win];
            we_q   <= we8[win];
            len_q  <= win_len;
            wrap_q <= win_wrap;
            state  <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_cmd_ready_i) begin
            beat_cnt <= len_q;
            state    <= we_q ? ST_WR : ST_RD;
          end
        end
        ST_WR: begin
          if (g_req && mem_wdat_ready_i) begin
            beat_cnt <= beat_cnt - 5'd1;
            if (beat_cnt == 5'd1) state <= ST_IDLE;
          end else if (!cyc8[grant]) begin
            state <= ST_PAD;
          end
        end
        ST_PAD: begin
          if (mem_wdat_ready_i) begin
            beat_cnt <= beat_cnt - 5'd1;
            if (beat_cnt == 5'd1) state <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (mem_rdat_valid_i) begin
            rd_dat_q <= mem_rdat_i;
            for (int p = 0; p < int'(n); p++) begin
              rd_ack_q[p] <= (grant == 3'(p)) & g_req;
            end
            beat_cnt <= beat_cnt - 5'd1;
            if (beat_cnt == 5'd1)  state <= ST_IDLE;
            else if (!cyc8[grant]) state <= ST_DRAIN;
          end else if (!cyc8[grant]) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_rdat_valid_i) begin
            beat_cnt <= beat_cnt - 5'd1;
            if (beat_cnt == 5'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_cmd_valid_o = (state == ST_CMD);
  assign mem_adr_o       = adr_q;
  assign mem_we_o        = we_q;
  assign mem_len_o       = len_q;
  assign mem_wrap_o      = wrap_q;
  assign mem_port_o      = grant;
  assign wb_ack_o        = wr_ack_c | rd_ack_q;
  assign wb_dat_o_v      = {n{rd_dat_q}};

endmodule

// File: tb/tb_vmc_wb_port_arb.sv
// Directed bench for vmc_wb_port_arb: round-robin instance plus a fixed-priority
// instance sharing the same port stimulus.
module tb_vmc_wb_port_arb;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              wb_clk = 1'b0;
  logic              wb_rst = 1'b0;
  logic [AW*N-1:0]   wb_adr_i_v;
  logic [DW*N-1:0]   wb_dat_i_v;
  logic [SW*N-1:0]   wb_sel_i_v;
  logic [3*N-1:0]    wb_cti_i_v;
  logic [2*N-1:0]    wb_bte_i_v;
  logic [N-1:0]      wb_we_i, wb_stb_i, wb_cyc_i;
  logic              mem_cmd_ready_i, mem_wdat_ready_i, mem_rdat_valid_i;
  logic [DW-1:0]     mem_rdat_i;

  logic [DW*N-1:0]   wb_dat_o_v,       fp_wb_dat_o_v;
  logic [N-1:0]      wb_ack_o,         fp_wb_ack_o;
  logic              mem_cmd_valid_o,  fp_mem_cmd_valid_o;
  logic [AW-1:0]     mem_adr_o,        fp_mem_adr_o;
  logic              mem_we_o,         fp_mem_we_o;
  logic [4:0]        mem_len_o,        fp_mem_len_o;
  logic              mem_wrap_o,       fp_mem_wrap_o;
  logic [2:0]        mem_port_o,       fp_mem_port_o;
  logic              mem_wdat_valid_o, fp_mem_wdat_valid_o;
  logic [DW-1:0]     mem_wdat_o,       fp_mem_wdat_o;
  logic [SW-1:0]     mem_wsel_o,       fp_mem_wsel_o;

  int n_cmp = 0;
  int n_bad = 0;
  int acks, bad, beats, zeros, first_k, first_port;
  int g_rr[$];
  int g_fp[$];

  always #5 wb_clk = ~wb_clk;

  vmc_wb_port_arb #(.nr_of_wb_ports(N), .adr_width(AW), .dat_width(DW), .arb_mode(0)) u_dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wb_adr_i_v(wb_adr_i_v), .wb_dat_i_v(wb_dat_i_v), .wb_sel_i_v(wb_sel_i_v),
    .wb_cti_i_v(wb_cti_i_v), .wb_bte_i_v(wb_bte_i_v),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_dat_o_v(wb_dat_o_v), .wb_ack_o(wb_ack_o),
    .mem_cmd_valid_o(mem_cmd_valid_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o), .mem_len_o(mem_len_o),
    .mem_wrap_o(mem_wrap_o), .mem_port_o(mem_port_o),
    .mem_wdat_valid_o(mem_wdat_valid_o), .mem_wdat_o(mem_wdat_o), .mem_wsel_o(mem_wsel_o),
    .mem_wdat_ready_i(mem_wdat_ready_i), .mem_rdat_valid_i(mem_rdat_valid_i),
    .mem_rdat_i(mem_rdat_i)
  );

  vmc_wb_port_arb #(.nr_of_wb_ports(N), .adr_width(AW), .dat_width(DW), .arb_mode(1)) u_dut_fp (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wb_adr_i_v(wb_adr_i_v), .wb_dat_i_v(wb_dat_i_v), .wb_sel_i_v(wb_sel_i_v),
    .wb_cti_i_v(wb_cti_i_v), .wb_bte_i_v(wb_bte_i_v),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_dat_o_v(fp_wb_dat_o_v), .wb_ack_o(fp_wb_ack_o),
    .mem_cmd_valid_o(fp_mem_cmd_valid_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_adr_o(fp_mem_adr_o), .mem_we_o(fp_mem_we_o), .mem_len_o(fp_mem_len_o),
    .mem_wrap_o(fp_mem_wrap_o), .mem_port_o(fp_mem_port_o),
    .mem_wdat_valid_o(fp_mem_wdat_valid_o), .mem_wdat_o(fp_mem_wdat_o), .mem_wsel_o(fp_mem_wsel_o),
    .mem_wdat_ready_i(mem_wdat_ready_i), .mem_rdat_valid_i(mem_rdat_valid_i),
    .mem_rdat_i(mem_rdat_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    wb_adr_i_v = '0; wb_dat_i_v = '0; wb_sel_i_v = '0;
    wb_cti_i_v = '0; wb_bte_i_v = '0;
    wb_we_i = '0; wb_stb_i = '0; wb_cyc_i = '0;
    mem_cmd_ready_i = 1'b0; mem_wdat_ready_i = 1'b0;
    mem_rdat_valid_i = 1'b0; mem_rdat_i = '0;
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [2:0] cti, input logic [1:0] bte);
    wb_cyc_i[p] = req;
    wb_stb_i[p] = req;
    wb_we_i[p]  = we;
    wb_adr_i_v[(N-1-p)*AW +: AW] = adr;
    wb_dat_i_v[(N-1-p)*DW +: DW] = dat;
    wb_sel_i_v[(N-1-p)*SW +: SW] = '1;
    wb_cti_i_v[(N-1-p)*3 +: 3]   = cti;
    wb_bte_i_v[(N-1-p)*2 +: 2]   = bte;
  endtask

  task automatic drop_port(input int p);
    wb_cyc_i[p] = 1'b0;
    wb_stb_i[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge wb_clk);
    wb_rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);
    #1;
    check("rst_cmd_valid", 64'(mem_cmd_valid_o), 0);
    check("rst_ack", 64'(wb_ack_o), 0);
    check("rst_wdat_valid", 64'(mem_wdat_valid_o), 0);
    check("rst_port", 64'(mem_port_o), 0);
    check("rst_len", 64'(mem_len_o), 0);
    check("rst_dat_o", 64'(|wb_dat_o_v), 0);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    check("rel_cmd_valid", 64'(mem_cmd_valid_o), 0);

    // Classic single write on port 1
    @(negedge wb_clk);
    set_port(1, 1'b1, 1'b1, 30'h100, 32'hA5A5_0001, 3'b000, 2'b00);
    @(negedge wb_clk); #1;
    check("t1_cmd_valid", 64'(mem_cmd_valid_o), 1);
    check("t1_adr", 64'(mem_adr_o), 64'h100);
    check("t1_len", 64'(mem_len_o), 1);
    check("t1_wrap", 64'(mem_wrap_o), 0);
    check("t1_port", 64'(mem_port_o), 1);
    check("t1_we", 64'(mem_we_o), 1);
    mem_cmd_ready_i = 1'b1;
    @(negedge wb_clk);
    mem_cmd_ready_i = 1'b0; #1;
    check("t1_wvalid", 64'(mem_wdat_valid_o), 1);
    check("t1_wdat", 64'(mem_wdat_o), 64'hA5A5_0001);
    check("t1_wsel", 64'(mem_wsel_o), 64'hF);
    check("t1_ack_wait", 64'(wb_ack_o), 0);
    @(negedge wb_clk);
    mem_wdat_ready_i = 1'b1; #1;
    check("t1_ack", 64'(wb_ack_o), 64'b010);
    @(negedge wb_clk);
    mem_wdat_ready_i = 1'b0;
    drop_port(1); #1;
    check("t1_idle_cmd", 64'(mem_cmd_valid_o), 0);
    check("t1_idle_ack", 64'(wb_ack_o), 0);

    // Wrap8 read on port 2
    @(negedge wb_clk);
    set_port(2, 1'b1, 1'b0, 30'h2C, 32'h0, 3'b010, 2'b10);
    @(negedge wb_clk); #1;
    check("t2_len", 64'(mem_len_o), 8);
    check("t2_wrap", 64'(mem_wrap_o), 1);
    check("t2_port", 64'(mem_port_o), 2);
    check("t2_we", 64'(mem_we_o), 0);
    check("t2_adr", 64'(mem_adr_o), 64'h2C);
    mem_cmd_ready_i = 1'b1;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge wb_clk);
      mem_cmd_ready_i = 1'b0;
      if (k == 8) drop_port(2);
      mem_rdat_valid_i = (k < 8);
      mem_rdat_i = 32'h1000 + 32'(k);
      #1;
      if (k >= 1 && k <= 8) begin
        check("t2_ack", 64'(wb_ack_o), 64'b100);
        check("t2_dat", 64'(wb_dat_o_v[DW-1:0]), 64'(32'h1000 + 32'(k) - 32'd1));
      end else begin
        check("t2_noack", 64'(wb_ack_o), 0);
      end
      if (wb_ack_o[2]) acks++;
    end
    mem_rdat_valid_i = 1'b0;
    check("t2_ack_count", 64'(acks), 8);
    check("t2_idle", 64'(mem_cmd_valid_o), 0);

    // Arbitration fairness: three ports request continuously
    do_reset();
    set_port(0, 1'b1, 1'b0, 30'h10, 32'h0, 3'b000, 2'b00);
    set_port(1, 1'b1, 1'b0, 30'h20, 32'h0, 3'b000, 2'b00);
    set_port(2, 1'b1, 1'b0, 30'h30, 32'h0, 3'b000, 2'b00);
    mem_cmd_ready_i  = 1'b1;
    mem_rdat_valid_i = 1'b1;
    for (int c = 0; c < 40 && (g_rr.size() < 6 || g_fp.size() < 6); c++) begin
      @(negedge wb_clk); #1;
      if (mem_cmd_valid_o && g_rr.size() < 6) g_rr.push_back(int'(mem_port_o));
      if (fp_mem_cmd_valid_o && g_fp.size() < 6) g_fp.push_back(int'(fp_mem_port_o));
    end
    check("t3_rr_count", 64'(g_rr.size()), 6);
    check("t3_fp_count", 64'(g_fp.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < g_rr.size()) check("t3_rr_grant", 64'(g_rr[i]), 64'(i % 3));
      if (i < g_fp.size()) check("t3_fp_grant", 64'(g_fp[i]), 0);
    end

    // Wrap4 write terminated after two beats: padded with sel=0
    do_reset();
    set_port(0, 1'b1, 1'b1, 30'h40, 32'hDEAD_0000, 3'b010, 2'b01);
    @(negedge wb_clk); #1;
    check("t4_len", 64'(mem_len_o), 4);
    check("t4_wrap", 64'(mem_wrap_o), 1);
    mem_cmd_ready_i = 1'b1;
    beats = 0; acks = 0; zeros = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge wb_clk);
      mem_cmd_ready_i  = 1'b0;
      mem_wdat_ready_i = 1'b1;
      if (acks == 2) drop_port(0);
      #1;
      if (mem_wdat_valid_o && mem_wdat_ready_i) beats++;
      if (mem_wdat_valid_o && mem_wdat_ready_i && mem_wsel_o == '0) zeros++;
      if (wb_ack_o[0]) acks++;
    end
    check("t4_beats", 64'(beats), 4);
    check("t4_acks", 64'(acks), 2);
    check("t4_pad_beats", 64'(zeros), 2);
    check("t4_idle_wvalid", 64'(mem_wdat_valid_o), 0);

    // Wrap16 read terminated after five acks: remaining beats drained
    do_reset();
    set_port(1, 1'b1, 1'b0, 30'h1F0, 32'h0, 3'b010, 2'b11);
    @(negedge wb_clk); #1;
    check("t5_len", 64'(mem_len_o), 16);
    check("t5_port", 64'(mem_port_o), 1);
    mem_cmd_ready_i = 1'b1;
    acks = 0; bad = 0; first_k = -1; first_port = -1;
    for (int k = 0; k < 24; k++) begin
      @(negedge wb_clk);
      mem_cmd_ready_i = 1'b0;
      if (k == 5) begin
        drop_port(1);
        set_port(0, 1'b1, 1'b0, 30'h8, 32'h0, 3'b000, 2'b00);
      end
      mem_rdat_valid_i = (k < 16);
      mem_rdat_i = 32'h2000 + 32'(k);
      #1;
      if (wb_ack_o[1]) acks++;
      if (wb_ack_o[0] || wb_ack_o[2]) bad++;
      if (mem_cmd_valid_o && first_k < 0) begin
        first_k    = k;
        first_port = int'(mem_port_o);
      end
    end
    check("t5_acks", 64'(acks), 5);
    check("t5_stray_acks", 64'(bad), 0);
    check("t5_next_cmd_cycle", 64'(first_k), 17);
    check("t5_next_port", 64'(first_port), 0);

    // Reset asserted in the middle of a wrap8 write
    do_reset();
    set_port(2, 1'b1, 1'b1, 30'h80, 32'hCAFE_0002, 3'b010, 2'b10);
    @(negedge wb_clk); #1;
    check("t6_len", 64'(mem_len_o), 8);
    mem_cmd_ready_i = 1'b1;
    @(negedge wb_clk);
    mem_cmd_ready_i  = 1'b0;
    mem_wdat_ready_i = 1'b1; #1;
    check("t6_beat1_ack", 64'(wb_ack_o), 64'b100);
    @(negedge wb_clk); #1;
    check("t6_beat2_ack", 64'(wb_ack_o), 64'b100);
    @(negedge wb_clk); #1;
    check("t6_beat3_valid", 64'(mem_wdat_valid_o), 1);
    wb_rst = 1'b0; #1;
    check("t6_rst_cmd_valid", 64'(mem_cmd_valid_o), 0);
    check("t6_rst_wvalid", 64'(mem_wdat_valid_o), 0);
    check("t6_rst_ack", 64'(wb_ack_o), 0);
    check("t6_rst_wdat", 64'(mem_wdat_o), 0);
    check("t6_rst_wsel", 64'(mem_wsel_o), 0);
    check("t6_rst_adr", 64'(mem_adr_o), 0);
    check("t6_rst_len", 64'(mem_len_o), 0);
    check("t6_rst_port", 64'(mem_port_o), 0);
    check("t6_rst_wrap", 64'(mem_wrap_o), 0);
    check("t6_rst_we", 64'(mem_we_o), 0);
    mem_wdat_ready_i = 1'b0;
    set_port(0, 1'b1, 1'b0, 30'h4, 32'h0, 3'b000, 2'b00);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk); #1;
    check("t6_regrant_valid", 64'(mem_cmd_valid_o), 1);
    check("t6_regrant_port", 64'(mem_port_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
